// File: rtl/hazard_ctrl_mc_if.sv
// Hazard controller bundle: pipeline-side hazard inputs and stall/flush/forward outputs.
interface hazard_ctrl_mc_if #(
    parameter int unsigned RA_W   = 5,
    parameter int unsigned PERF_W = 16
);
    logic [RA_W-1:0]   rs_d;
    logic [RA_W-1:0]   rt_d;
    logic              use_rs_d;
    logic              use_rt_d;
    logic [RA_W-1:0]   rs_e;
    logic [RA_W-1:0]   rt_e;
    logic              load_e;
    logic [RA_W-1:0]   write_reg_e;
    logic              reg_write_m;
    logic [RA_W-1:0]   write_reg_m;
    logic              reg_write_w;
    logic [RA_W-1:0]   write_reg_w;
    logic              branch_taken_e;
    logic              mc_start_e;
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              flush_d;
    logic              flush_e;
    logic              flush_m;
    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;
    logic              mc_busy;
    logic [PERF_W-1:0] stall_cnt;

    // Pipeline side: drives hazard sources, consumes control.
    modport master (
        output rs_d, rt_d, use_rs_d, use_rt_d, rs_e, rt_e, load_e, write_reg_e,
               reg_write_m, write_reg_m, reg_write_w, write_reg_w,
               branch_taken_e, mc_start_e,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               forward_a_e, forward_b_e, mc_busy, stall_cnt
    );

    // Hazard controller side.
    modport slave (
        input  rs_d, rt_d, use_rs_d, use_rt_d, rs_e, rt_e, load_e, write_reg_e,
               reg_write_m, write_reg_m, reg_write_w, write_reg_w,
               branch_taken_e, mc_start_e,
        output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               forward_a_e, forward_b_e, mc_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller: EX forwarding, load-use stall, branch flush,
// multi-cycle EX freeze sequencer and saturating stall-cycle counter.
module hazard_ctrl_mc #(
    parameter int unsigned RA_W   = 5,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned PERF_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    hazard_ctrl_mc_if.slave hz
);
    localparam int unsigned CNT_W = $clog2(MC_LAT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic                stall_f_c, stall_d_c, stall_e_c;
    logic                flush_d_c, flush_e_c, flush_m_c;
    logic [1:0]          fwd_a_c, fwd_b_c;
    logic                lu_c;

    // Forward select for one source: M beats W, register 0 never matches.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic            wr_m,
        input logic [RA_W-1:0] dst_m,
        input logic            wr_w,
        input logic [RA_W-1:0] dst_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (dst_m != '0) && (dst_m == src)) begin
            sel = 2'b10;
        end else if (wr_w && (dst_w != '0) && (dst_w == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Hazard decode, freeze sequencing and next-state for all registers.
    always_comb begin
        stall_f_c   = 1'b0;
        stall_d_c   = 1'b0;
        stall_e_c   = 1'b0;
        flush_d_c   = 1'b0;
        flush_e_c   = 1'b0;
        flush_m_c   = 1'b0;
        fwd_a_c     = 2'b00;
        fwd_b_c     = 2'b00;
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;

        lu_c = hz.load_e && (hz.write_reg_e != '0) &&
               ((hz.use_rs_d && (hz.rs_d == hz.write_reg_e)) ||
                (hz.use_rt_d && (hz.rt_d == hz.write_reg_e)));

        if (!rst) begin
            fwd_a_c = fwd_sel(hz.rs_e, hz.reg_write_m, hz.write_reg_m,
                              hz.reg_write_w, hz.write_reg_w);
            fwd_b_c = fwd_sel(hz.rt_e, hz.reg_write_m, hz.write_reg_m,
                              hz.reg_write_w, hz.write_reg_w);

            if (state_q == S_BUSY) begin
                // E frozen: new starts, branches and load-use are masked.
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                stall_e_c = 1'b1;
                flush_m_c = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end else if (hz.mc_start_e && !hz.branch_taken_e) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                stall_e_c = 1'b1;
                flush_m_c = 1'b1;
                state_d   = S_BUSY;
                cnt_d     = CNT_W'(MC_LAT - 1);
            end else if (hz.branch_taken_e) begin
                // D instruction is squashed, so a load-use stall is moot.
                flush_d_c = 1'b1;
                flush_e_c = 1'b1;
            end else if (lu_c) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                flush_e_c = 1'b1;
            end

            if (stall_f_c && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + PERF_W'(1);
            end
        end
    end

    // State, latency counter and performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_f     = stall_f_c;
    assign hz.stall_d     = stall_d_c;
    assign hz.stall_e     = stall_e_c;
    assign hz.flush_d     = flush_d_c;
    assign hz.flush_e     = flush_e_c;
    assign hz.flush_m     = flush_m_c;
    assign hz.forward_a_e = fwd_a_c;
    assign hz.forward_b_e = fwd_b_c;
    assign hz.mc_busy     = (state_q == S_BUSY);
    assign hz.stall_cnt   = stall_cnt_q;
endmodule
